// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the fetch/decode/execute cycle: Moore outputs decoded from state and latched opcode.
// Define MEM_WAIT_EN to stall memory-access states (T1, ld T6, st T7) until mem_ready.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_lo_out,
  output logic        c_out,
  output logic        con_in,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_BR, C_HALT
  } cls_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  function automatic cls_t classify(input logic [4:0] op);
    cls_t c;
    c = C_NONE;
    if (op == 5'b00000)                        c = C_LD;
    else if (op == 5'b00001)                   c = C_LDI;
    else if (op == 5'b00010)                   c = C_ST;
    else if (op >= 5'b00011 && op <= 5'b01011) c = C_RALU;
    else if (op >= 5'b01100 && op <= 5'b01110) c = C_IALU;
    else if (op == 5'b10010)                   c = C_BR;
    else if (op == 5'b11010)                   c = C_HALT;
    return c;
  endfunction

  state_t     state, state_next;
  logic [4:0] op_q;
  logic [4:0] op;
  cls_t       cls;
  logic       mem_hold;

`ifdef MEM_WAIT_EN
  assign mem_hold = !mem_ready;
  logic unused_bits;
  assign unused_bits = &{1'b0, ir[26:0]};
`else
  assign mem_hold = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, ir[26:0], mem_ready};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) state <= S_T0;
    else     state <= state_next;
  end

  // NOTE: op_q is a pure data holding register; it is always written in T3 before use, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_T3) op_q <= ir[31:27];
  end

  // In T3 the IR has just been loaded, so decode straight from it; later steps use the captured copy.
  assign op  = (state == S_T3) ? ir[31:27] : op_q;
  assign cls = classify(op);

  always_comb begin
    state_next = S_T0;
    unique case (state)
      S_T0: state_next = S_T1;
      S_T1: state_next = mem_hold ? S_T1 : S_T2;
      S_T2: state_next = S_T3;
      S_T3: begin
        if (cls == C_HALT)      state_next = S_HALT;
        else if (cls == C_NONE) state_next = S_T0;
        else                    state_next = S_T4;
      end
      S_T4: state_next = S_T5;
      S_T5: state_next = (cls == C_LD || cls == C_ST || cls == C_BR) ? S_T6 : S_T0;
      S_T6: begin
        if (cls == C_LD)      state_next = mem_hold ? S_T6 : S_T7;
        else if (cls == C_ST) state_next = S_T7;
        else                  state_next = S_T0;
      end
      S_T7:   state_next = (cls == C_ST && mem_hold) ? S_T7 : S_T0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_T0;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0;
    mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; z_lo_out = 1'b0; c_out = 1'b0;
    con_in = 1'b0; read = 1'b0; write = 1'b0;
    alu_op = 5'b00000;
    run = 1'b1;
    if (!clr) begin
      unique case (state)
        S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
        S_T1: begin z_lo_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
        S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
        S_T3: begin
          unique case (cls)
            C_LD, C_LDI, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
            C_RALU, C_IALU:    begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
            C_BR:              begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
            default: ;
          endcase
        end
        S_T4: begin
          unique case (cls)
            C_RALU:            begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op; end
            C_IALU:            begin c_out = 1'b1; z_in = 1'b1; alu_op = op; end
            C_LD, C_LDI, C_ST: begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
            C_BR:              begin pc_out = 1'b1; y_in = 1'b1; end
            default: ;
          endcase
        end
        S_T5: begin
          unique case (cls)
            C_RALU, C_IALU, C_LDI: begin z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            C_LD, C_ST:            begin z_lo_out = 1'b1; mar_in = 1'b1; end
            C_BR:                  begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
            default: ;
          endcase
        end
        S_T6: begin
          unique case (cls)
            C_LD: begin read = 1'b1; mdr_in = 1'b1; end
            C_ST: begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
            C_BR: begin z_lo_out = 1'b1; pc_in = con_ff; end
            default: ;
          endcase
        end
        S_T7: begin
          unique case (cls)
            C_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            C_ST: write = 1'b1;
            default: ;
          endcase
        end
        S_HALT: run = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the expected output word for each cycle, a negedge monitor pops and compares.
module tb_control_sequencer;

  logic        clk, clr, con_ff, mem_ready;
  logic [31:0] ir;
  logic gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out;
  logic ir_in, y_in, z_in, z_lo_out, c_out, con_in, read, write, run;
  logic [4:0] alu_op;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .z_lo_out(z_lo_out),
    .c_out(c_out), .con_in(con_in), .read(read), .write(write), .alu_op(alu_op), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout: {gra..write, alu_op, run}
  localparam logic [25:0] RUN = 26'd1;
  localparam logic [25:0] WRITE = 26'd1 << 6,  READ = 26'd1 << 7,  CON_IN = 26'd1 << 8;
  localparam logic [25:0] C_OUT = 26'd1 << 9,  Z_LO = 26'd1 << 10, Z_IN = 26'd1 << 11;
  localparam logic [25:0] Y_IN = 26'd1 << 12,  IR_IN = 26'd1 << 13, MDR_OUT = 26'd1 << 14;
  localparam logic [25:0] MDR_IN = 26'd1 << 15, MAR_IN = 26'd1 << 16, INC_PC = 26'd1 << 17;
  localparam logic [25:0] PC_IN = 26'd1 << 18, PC_OUT = 26'd1 << 19, BA_OUT = 26'd1 << 20;
  localparam logic [25:0] R_OUT = 26'd1 << 21, R_IN = 26'd1 << 22, GRC = 26'd1 << 23;
  localparam logic [25:0] GRB = 26'd1 << 24, GRA = 26'd1 << 25;

  localparam logic [25:0] E_T0 = RUN | PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam logic [25:0] E_T1 = RUN | Z_LO | PC_IN | READ | MDR_IN;
  localparam logic [25:0] E_T2 = RUN | MDR_OUT | IR_IN;
  localparam logic [25:0] E_ADR3 = RUN | GRB | BA_OUT | Y_IN;
  localparam logic [25:0] E_ADR4 = RUN | C_OUT | Z_IN | (26'd3 << 1);
  localparam logic [25:0] E_WB = RUN | Z_LO | GRA | R_IN;
  localparam logic [25:0] E_RD3 = RUN | GRB | R_OUT | Y_IN;

  function automatic logic [25:0] alu(input logic [4:0] op);
    return 26'(op) << 1;
  endfunction

  typedef struct {
    string       name;
    logic [25:0] vec;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input logic [25:0] act, input logic [25:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, expv);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      check(cur.name, {gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, inc_pc, mar_in,
                       mdr_in, mdr_out, ir_in, y_in, z_in, z_lo_out, c_out, con_in, read,
                       write, alu_op, run}, cur.vec);
    end
  end

  task automatic cyc(input string nm, input logic [25:0] e);
    sb_q.push_back('{nm, e});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] iv);
    ir = iv;
    cyc({tag, "_t0"}, E_T0);
    cyc({tag, "_t1"}, E_T1);
    cyc({tag, "_t2"}, E_T2);
  endtask

  task automatic reg_alu(input string tag, input logic [31:0] iv);
    fetch(tag, iv);
    cyc({tag, "_t3"}, E_RD3);
    cyc({tag, "_t4"}, RUN | GRC | R_OUT | Z_IN | alu(iv[31:27]));
    cyc({tag, "_t5"}, E_WB);
  endtask

  task automatic imm_alu(input string tag, input logic [31:0] iv);
    fetch(tag, iv);
    cyc({tag, "_t3"}, E_RD3);
    cyc({tag, "_t4"}, RUN | C_OUT | Z_IN | alu(iv[31:27]));
    cyc({tag, "_t5"}, E_WB);
  endtask

  task automatic branch(input string tag, input logic cond);
    con_ff = ~cond;
    fetch(tag, 32'h9000_0000);
    cyc({tag, "_t3"}, RUN | GRA | R_OUT | CON_IN);
    cyc({tag, "_t4"}, RUN | PC_OUT | Y_IN);
    cyc({tag, "_t5"}, RUN | C_OUT | Z_IN | (26'd3 << 1));
    con_ff = cond;
    cyc({tag, "_t6"}, RUN | Z_LO | (cond ? PC_IN : 26'd0));
    con_ff = 1'b0;
  endtask

  initial begin
    int waited;
    clr = 1'b1; ir = 32'h0; con_ff = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_clr", RUN);
    clr = 1'b0;

    // add r3,r1,r2
    reg_alu("add", 32'h1989_0000);
    // highest register-ALU opcode
    reg_alu("ralu_top", 32'h5800_0000);
    imm_alu("addi", 32'h6000_0000);
    imm_alu("ialu_top", 32'h7000_0000);

    // ldi
    fetch("ldi", 32'h0800_0000);
    cyc("ldi_t3", E_ADR3);
    cyc("ldi_t4", E_ADR4);
    cyc("ldi_t5", E_WB);

    // ld r2,0x55(r0)
    fetch("ld", 32'h0100_0055);
    cyc("ld_t3", E_ADR3);
    cyc("ld_t4", E_ADR4);
    cyc("ld_t5", RUN | Z_LO | MAR_IN);
    cyc("ld_t6", RUN | READ | MDR_IN);
    cyc("ld_t7", RUN | MDR_OUT | GRA | R_IN);

    fetch("st", 32'h1000_0000);
    cyc("st_t3", E_ADR3);
    cyc("st_t4", E_ADR4);
    cyc("st_t5", RUN | Z_LO | MAR_IN);
    cyc("st_t6", RUN | GRA | R_OUT | MDR_IN);
    cyc("st_t7", RUN | WRITE);

    branch("br_nt", 1'b0);
    branch("br_t", 1'b1);

    fetch("nop", 32'hC800_0000);
    cyc("nop_t3", RUN);
    fetch("undef", 32'hF800_0000);
    cyc("undef_t3", RUN);

    // clr in the middle of a load: T5 outputs suppressed, then a clean fetch
    fetch("ld_abort", 32'h0100_0055);
    cyc("ld_abort_t3", E_ADR3);
    cyc("ld_abort_t4", E_ADR4);
    clr = 1'b1;
    cyc("ld_abort_clr", RUN);
    clr = 1'b0;
    reg_alu("after_abort", 32'h1989_0000);

`ifdef MEM_WAIT_EN
    ir = 32'h1989_0000;
    cyc("wait_t0", E_T0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("wait_t1_hold", E_T1);
    mem_ready = 1'b1;
    cyc("wait_t1_done", E_T1);
    cyc("wait_t2", E_T2);
    cyc("wait_t3", E_RD3);
    cyc("wait_t4", RUN | GRC | R_OUT | Z_IN | alu(5'b00011));
    cyc("wait_t5", E_WB);
`else
    ir = 32'h1989_0000;
    cyc("nowait_t0", E_T0);
    mem_ready = 1'b0;
    cyc("nowait_t1", E_T1);
    cyc("nowait_t2", E_T2);
    mem_ready = 1'b1;
    cyc("nowait_t3", E_RD3);
    cyc("nowait_t4", RUN | GRC | R_OUT | Z_IN | alu(5'b00011));
    cyc("nowait_t5", E_WB);
`endif

    // halt, then held for 20 cycles, then released by clr
    fetch("halt", 32'hD000_0000);
    cyc("halt_t3", RUN);
    for (int i = 0; i < 20; i++) cyc("halt_hold", 26'd0);
    clr = 1'b1;
    cyc("halt_clr", RUN);
    clr = 1'b0;
    fetch("post_halt", 32'h1989_0000);

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 The block SHALL have ports: clr  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: ir  in  32  current instruction; opcode ir[31:27].
REQ-004 The block SHALL have ports: con_ff  in  1  branch-condition flag from the CON FF.
REQ-005 The block SHALL have ports: mem_ready  in  1  memory completion strobe, used only under MEM_WAIT_EN.
REQ-006 The block SHALL have ports: gra, grb, grc  out  1 each  register-field selects to the select/encode stage.
REQ-007 The block SHALL have ports: r_in, r_out, ba_out  out  1 each  register-file write enable, read enable, base-address read.
REQ-008 The block SHALL have ports: pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, z_lo_out, c_out, con_in, read, write  out  1 each  datapath strobes.
REQ-009 The block SHALL have ports: alu_op  out  5  ALU operation code.
REQ-010 The block SHALL have ports: run  out  1  high until halt.
REQ-011 One clock; reset is synchronous and active-high (clk, clr).

Function
REQ-012 States SHALL be T0..T7 and HALT; outputs Moore-decoded from state and latched ir; every output not listed for a state is 0.
REQ-013 T0: pc_out, mar_in, inc_pc, z_in. T1: z_lo_out, pc_in, read, mdr_in. T2: mdr_out, ir_in. T0->T1->T2->T3, one cycle each.
REQ-014 T3 decode: opcode 00000 ld, 00001 ldi, 00010 st, 00011..01011 reg ALU, 01100..01110 imm ALU, 10010 br, 11010 halt. Opcode 11001 (nop) and any other opcode: T3 asserts nothing, then T0.
REQ-015 Reg ALU: T3 grb,r_out,y_in; T4 grc,r_out,z_in, alu_op=opcode; T5 z_lo_out,gra,r_in; then T0.
REQ-016 Imm ALU: T3 grb,r_out,y_in; T4 c_out,z_in, alu_op=opcode; T5 z_lo_out,gra,r_in; then T0.
REQ-017 ldi: T3 grb,ba_out,y_in; T4 c_out,z_in, alu_op=00011; T5 z_lo_out,gra,r_in; then T0.
REQ-018 ld: T3-T4 as ldi; T5 z_lo_out,mar_in; T6 read,mdr_in; T7 mdr_out,gra,r_in; then T0.
REQ-019 st: T3-T5 as ld; T6 gra,r_out,mdr_in; T7 write; then T0.
REQ-020 br: T3 gra,r_out,con_in; T4 pc_out,y_in; T5 c_out,z_in, alu_op=00011; T6 z_lo_out, pc_in only if con_ff=1 sampled in T6; then T0.
REQ-021 halt: T3->HALT; HALT asserts only run=0 and is left only by clr.
REQ-022 alu_op SHALL be 00000 in every state not named above.
REQ-023 At most one of gra/grb/grc SHALL be high in any cycle; r_in and r_out never high together.

Reset
REQ-024 clr=1 at a rising edge SHALL force state T0 and run=1 on the next cycle, from any state including HALT and mid-instruction; the abandoned instruction has no further effect.
REQ-025 While clr is high, all strobes and alu_op SHALL be 0 and run=1.

Configuration
REQ-026 Macro MEM_WAIT_EN defined: T1, ld T6 and st T7 SHALL hold state and keep read/write asserted until a cycle with mem_ready=1, then advance next edge; clr still overrides.
REQ-027 MEM_WAIT_EN undefined: those states last exactly one cycle; mem_ready ignored.

Verification
REQ-028 clr 1 cycle, ir=0x19890000 (add r3,r1,r2) -> T0..T5 in 6 cycles; T4 grc=1, alu_op=00011; T5 gra=1, r_in=1; T0 next.
REQ-029 ir=0x01000055 (ld r2,0x55(r0)) -> 8-cycle instruction; T3 grb=1, ba_out=1; T6 read=1; T7 gra=1, r_in=1.
REQ-030 br with con_ff=0 then con_ff=1 -> T6 pc_in=0 then pc_in=1; con_in=1 in T3 both times.
REQ-031 ir=0xD0000000 -> HALT after T3, run=0 held 20 cycles; clr -> T0, run=1.
REQ-032 clr asserted in ld T5 -> next cycle T0, no mar_in/read pulse from the aborted ld.
REQ-033 MEM_WAIT_EN, mem_ready low 3 cycles in T1 -> read held 4 cycles, T2 follows mem_ready=1.
